// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// FIFO_ARB_TAG_EN widens the FIFO write word with the granted requester index.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

`ifdef FIFO_ARB_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    // FIFO word width for a given data width and index width.
    function automatic int wdata_width(input int width, input int idw);
        return width + TAG_EN * idw;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO handshake bundle of the write arbiter.
// FIFO_ARB_TAG_EN (through fifo_arb_pkg) sets the default FIFO word width.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = $clog2(NREQ),
    parameter int DW    = wdata_width(WIDTH, IDW)
);

    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic [NREQ-1:0]       req_ready_o;
    logic                  fifo_full_i;
    logic                  fifo_wr_en_o;
    logic [DW-1:0]         fifo_wdata_o;
    logic [IDW-1:0]        grant_id_o;
    logic                  busy_o;

    modport master (
        input  req_valid_i, req_data_i, fifo_full_i,
        output req_ready_o, fifo_wr_en_o, fifo_wdata_o, grant_id_o, busy_o
    );

    modport slave (
        output req_valid_i, req_data_i, fifo_full_i,
        input  req_ready_o, fifo_wr_en_o, fifo_wdata_o, grant_id_o, busy_o
    );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority search: first set bit of valid at or above ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [IDW-1:0] probe_s;

    // Walk NREQ positions from ptr; the first hit wins, idx stays at ptr when none.
    always_comb begin
        probe_s = '0;
        idx     = ptr;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            probe_s = IDW'((int'(ptr) + i) % NREQ);
            idx     = (!found && valid[probe_s]) ? probe_s : idx;
            found   = found | valid[probe_s];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter merging NREQ write requesters into one FIFO.
// Define FIFO_ARB_TAG_EN to prefix each FIFO word with the requester index.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_wr_arbiter_if.master bus
);

    arb_state_e      state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  owner_r;
    logic [7:0]      beat_cnt_r;
    logic            busy_r;

    logic [IDW-1:0]  pick_idx_s;
    logic            pick_found_s;
    logic [IDW-1:0]  cand_s;
    logic            cand_valid_s;
    logic [WIDTH-1:0] cand_data_s;
    logic            beat_s;
    logic [NREQ-1:0] ready_s;
    logic [IDW-1:0]  grant_s;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end else begin
            return i + IDW'(1);
        end
    endfunction

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .valid (bus.req_valid_i),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Candidate selection, handshake and grant display; reset blanks every output.
    always_comb begin
        cand_s       = pick_idx_s;
        cand_data_s  = '0;
        ready_s      = '0;
        grant_s      = '0;
        if (state_r == BURST) begin
            cand_s = owner_r;
        end else begin
            cand_s = pick_idx_s;
        end
        cand_valid_s = bus.req_valid_i[cand_s];
        for (int n = 0; n < NREQ; n++) begin
            cand_data_s = (IDW'(n) == cand_s) ? bus.req_data_i[n*WIDTH +: WIDTH] : cand_data_s;
        end
        beat_s = cand_valid_s && !bus.fifo_full_i && !rst_i;
        if (beat_s) begin
            ready_s[cand_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
        if (rst_i) begin
            grant_s = '0;
        end else if (|bus.req_valid_i) begin
            grant_s = cand_s;
        end else begin
            grant_s = rr_ptr_r;
        end
    end

    assign bus.req_ready_o  = ready_s;
    assign bus.fifo_wr_en_o = |(bus.req_valid_i & ready_s);
    assign bus.grant_id_o   = grant_s;
    assign bus.busy_o       = busy_r;
`ifdef FIFO_ARB_TAG_EN
    assign bus.fifo_wdata_o = rst_i ? '0 : {cand_s, cand_data_s};
`else
    assign bus.fifo_wdata_o = rst_i ? '0 : cand_data_s;
`endif

    // Burst FSM; a full FIFO freezes everything so the grant never rotates on a stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= 8'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (beat_s) begin
                        if (MAX_BURST > 1) begin
                            owner_r    <= cand_s;
                            beat_cnt_r <= 8'd1;
                            state_r    <= BURST;
                            busy_r     <= 1'b1;
                        end else begin
                            rr_ptr_r <= next_idx(cand_s);
                        end
                    end
                end
                BURST: begin
                    if (bus.fifo_full_i) begin
                        state_r <= BURST;
                    end else if (!cand_valid_s) begin
                        // Owner went quiet: give up the grant after this bubble.
                        rr_ptr_r   <= next_idx(owner_r);
                        beat_cnt_r <= 8'd0;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end else if (beat_cnt_r + 8'd1 == 8'(MAX_BURST)) begin
                        rr_ptr_r   <= next_idx(owner_r);
                        beat_cnt_r <= 8'd0;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (MAX_BURST 4 and 1 instances).
// Honours FIFO_ARB_TAG_EN for the expected FIFO word format.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int DW    = WIDTH + TAG_EN * IDW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .DW(DW)) bus  ();
    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .DW(DW)) bus1 ();

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4), .IDW(IDW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(1), .IDW(IDW)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.master)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_wdata(input logic [1:0] id);
`ifdef FIFO_ARB_TAG_EN
        return {id, dat[id]};
`else
        return dat[id];
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i  = 4'b0000;
        bus.fifo_full_i  = 1'b0;
        bus1.req_valid_i = 4'b0000;
        bus1.fifo_full_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i = 4'b1111;
        #1;
        n_checks++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", bus.req_ready_o); end
        n_checks++; if (bus.fifo_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en_o); end
        n_checks++; if (bus.fifo_wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", bus.fifo_wdata_o); end
        n_checks++; if (bus.grant_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", bus.grant_id_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_burst_rr();
        logic [1:0] eg;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b0101;
            #1;
            eg = ((k / 4) % 2 == 1) ? 2'd2 : 2'd0;
            n_checks++; if (bus.grant_id_o !== eg) begin n_fail++; $display("FAIL burst_grant c%0d got %0d want %0d", k, bus.grant_id_o, eg); end
            n_checks++; if (bus.req_ready_o !== (4'b0001 << eg)) begin n_fail++; $display("FAIL burst_ready c%0d got %b want %b", k, bus.req_ready_o, 4'b0001 << eg); end
            n_checks++; if (bus.fifo_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL burst_wr_en c%0d got %b want 1", k, bus.fifo_wr_en_o); end
            n_checks++; if (bus.fifo_wdata_o !== exp_wdata(eg)) begin n_fail++; $display("FAIL burst_wdata c%0d got %h want %h", k, bus.fifo_wdata_o, exp_wdata(eg)); end
            n_checks++; if (bus.busy_o !== (k % 4 != 0)) begin n_fail++; $display("FAIL burst_busy c%0d got %b want %b", k, bus.busy_o, (k % 4 != 0)); end
        end
    endtask

    task automatic test_owner_drop();
        logic [1:0] eg;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b1110;
            #1;
            n_checks++; if (bus.grant_id_o !== 2'd1 || bus.fifo_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL drop_pre c%0d got grant %0d wr_en %b want 1/1", k, bus.grant_id_o, bus.fifo_wr_en_o); end
        end
        @(negedge clk);
        bus.req_valid_i = 4'b1101;
        #1;
        n_checks++; if (bus.fifo_wr_en_o !== 1'b0 || bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL drop_bubble got wr_en %b ready %b want 0/0000", bus.fifo_wr_en_o, bus.req_ready_o); end
        n_checks++; if (bus.grant_id_o !== 2'd1 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL drop_bubble_grant got grant %0d busy %b want 1/1", bus.grant_id_o, bus.busy_o); end
        for (int k = 3; k < 12; k++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b1101;
            #1;
            eg = (k <= 6) ? 2'd2 : ((k <= 10) ? 2'd3 : 2'd0);
            n_checks++; if (bus.grant_id_o !== eg) begin n_fail++; $display("FAIL drop_grant c%0d got %0d want %0d", k, bus.grant_id_o, eg); end
            n_checks++; if (bus.fifo_wr_en_o !== 1'b1) begin n_fail++; $display("FAIL drop_wr_en c%0d got %b want 1", k, bus.fifo_wr_en_o); end
        end
    endtask

    task automatic test_full_stall();
        logic [1:0] eg;
        logic       ef;
        logic       eb;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ef = (k >= 2 && k <= 4);
            bus.req_valid_i = 4'b0011;
            bus.fifo_full_i = ef;
            #1;
            eg = (k == 7) ? 2'd1 : 2'd0;
            eb = (k >= 1 && k <= 6);
            n_checks++; if (bus.grant_id_o !== eg) begin n_fail++; $display("FAIL stall_grant c%0d got %0d want %0d", k, bus.grant_id_o, eg); end
            n_checks++; if (bus.req_ready_o !== (ef ? 4'b0000 : (4'b0001 << eg))) begin n_fail++; $display("FAIL stall_ready c%0d got %b", k, bus.req_ready_o); end
            n_checks++; if (bus.fifo_wr_en_o !== !ef) begin n_fail++; $display("FAIL stall_wr_en c%0d got %b want %b", k, bus.fifo_wr_en_o, !ef); end
            n_checks++; if (bus.busy_o !== eb) begin n_fail++; $display("FAIL stall_busy c%0d got %b want %b", k, bus.busy_o, eb); end
        end
        bus.fifo_full_i = 1'b0;
    endtask

    task automatic test_single_beat();
        logic [1:0] eg;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus1.req_valid_i = 4'b1111;
            #1;
            eg = 2'(k % 4);
            n_checks++; if (bus1.grant_id_o !== eg) begin n_fail++; $display("FAIL single_grant c%0d got %0d want %0d", k, bus1.grant_id_o, eg); end
            n_checks++; if (bus1.req_ready_o !== (4'b0001 << eg)) begin n_fail++; $display("FAIL single_ready c%0d got %b", k, bus1.req_ready_o); end
            n_checks++; if (bus1.fifo_wr_en_o !== 1'b1 || bus1.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_wr_busy c%0d got %b/%b want 1/0", k, bus1.fifo_wr_en_o, bus1.busy_o); end
        end
        bus1.req_valid_i = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.req_valid_i = 4'b1000;
            #1;
            n_checks++; if (bus.grant_id_o !== 2'd3) begin n_fail++; $display("FAIL areset_pre c%0d got %0d want 3", k, bus.grant_id_o); end
        end
        @(negedge clk);
        bus.req_valid_i = 4'b1111;
        #1;
        n_checks++; if (bus.grant_id_o !== 2'd3 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL areset_owner got grant %0d busy %b want 3/1", bus.grant_id_o, bus.busy_o); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.req_ready_o !== 4'b0000 || bus.fifo_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL areset_hs got ready %b wr_en %b want 0000/0", bus.req_ready_o, bus.fifo_wr_en_o); end
        n_checks++; if (bus.fifo_wdata_o !== '0 || bus.grant_id_o !== 2'd0) begin n_fail++; $display("FAIL areset_data got wdata %h grant %0d want 0/0", bus.fifo_wdata_o, bus.grant_id_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", bus.busy_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.grant_id_o !== 2'd0 || bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL areset_after got grant %0d ready %b want 0/0001", bus.grant_id_o, bus.req_ready_o); end
        n_checks++; if (bus.fifo_wr_en_o !== 1'b1 || bus.fifo_wdata_o !== exp_wdata(2'd0)) begin n_fail++; $display("FAIL areset_after_wr got %b %h want 1 %h", bus.fifo_wr_en_o, bus.fifo_wdata_o, exp_wdata(2'd0)); end
    endtask

    task automatic test_tag();
        logic [DW-1:0] ew;
`ifdef FIFO_ARB_TAG_EN
        ew = 10'h2A5;
`else
        ew = 8'hA5;
`endif
        do_reset();
        @(negedge clk);
        bus.req_valid_i = 4'b0100;
        #1;
        n_checks++; if (bus.grant_id_o !== 2'd2) begin n_fail++; $display("FAIL tag_grant got %0d want 2", bus.grant_id_o); end
        n_checks++; if (bus.fifo_wdata_o !== ew) begin n_fail++; $display("FAIL tag_wdata got %h want %h", bus.fifo_wdata_o, ew); end
    endtask

    initial begin
        bus.req_valid_i  = 4'b0000;
        bus.req_data_i   = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.fifo_full_i  = 1'b0;
        bus1.req_valid_i = 4'b0000;
        bus1.req_data_i  = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus1.fifo_full_i = 1'b0;
        test_reset();
        test_burst_rr();
        test_owner_drop();
        test_full_stall();
        test_single_beat();
        test_async_reset();
        test_tag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, requester data width; equals the FIFO WIDTH.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant (1..255).
REQ-004 SHALL have parameter IDW, default $clog2(NREQ), requester-index width.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state updates on posedge.
REQ-006 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, NREQ; bit n means requester n has a word.
REQ-008 SHALL have port req_data_i, input, NREQ*WIDTH; slice n holds requester n data.
REQ-009 SHALL have port req_ready_o, output, NREQ; one-hot or zero; bit n means the word is accepted this cycle.
REQ-010 SHALL have port fifo_full_i, input, 1, the FIFO full flag.
REQ-011 SHALL have port fifo_wr_en_o, output, 1, the FIFO write enable.
REQ-012 SHALL have port fifo_wdata_o, output, WIDTH (WIDTH+IDW with tag), the FIFO write data.
REQ-013 SHALL have port grant_id_o, output, IDW, index of the current or candidate grantee.
REQ-014 SHALL have port busy_o, output, 1; high in BURST.

Function
REQ-015 SHALL implement FSM states IDLE and BURST, plus rr_ptr (IDW bits) and beat_cnt (8 bits).
REQ-016 In IDLE, the candidate SHALL be the first asserted req_valid_i bit found searching upward from rr_ptr with wrap.
REQ-017 In BURST, the candidate SHALL be the latched owner only.
REQ-018 req_ready_o[c] SHALL equal candidate valid AND NOT fifo_full_i, combinationally.
REQ-019 fifo_wr_en_o SHALL equal OR of (req_valid_i AND req_ready_o); fifo_wdata_o SHALL be the candidate slice, zero latency.
REQ-020 On an IDLE beat with MAX_BURST>1: latch owner=c, beat_cnt=1, go to BURST.
REQ-021 On an IDLE beat with MAX_BURST==1: set rr_ptr=c+1 mod NREQ, stay in IDLE.
REQ-022 On a BURST beat: increment beat_cnt; if it reaches MAX_BURST, set rr_ptr=owner+1 mod NREQ and go to IDLE.
REQ-023 In BURST with owner valid low: no transfer; set rr_ptr=owner+1 mod NREQ and go to IDLE next cycle (one bubble).
REQ-024 While fifo_full_i is high: no transfer; state, beat_cnt and rr_ptr unchanged; grant held (no rotation on stall).
REQ-025 Non-owner valids SHALL be ignored in BURST; requesters hold data and valid until ready.
REQ-026 grant_id_o SHALL show the candidate, or rr_ptr when no valid is asserted.

Reset
REQ-027 rst_i high SHALL immediately force IDLE, rr_ptr=0, beat_cnt=0, and owner=0.
REQ-028 While rst_i is high, req_ready_o, fifo_wr_en_o, fifo_wdata_o and busy_o SHALL be 0; grant_id_o SHALL be 0.
REQ-029 Reset mid-burst SHALL abort the burst; after release, arbitration restarts from requester 0.

Configuration
REQ-030 Macro FIFO_ARB_TAG_EN defined: fifo_wdata_o is WIDTH+IDW bits, {candidate index, data}.
REQ-031 FIFO_ARB_TAG_EN undefined: fifo_wdata_o is WIDTH bits of data only; behaviour otherwise identical.

Structure
REQ-032 Shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the default NREQ, WIDTH and MAX_BURST constants.
REQ-033 Sub-module rr_picker SHALL be the combinational rotating priority search, taking valid vector and rr_ptr and returning index and found.

Verification
REQ-034 Reset then valid=4'b0101, full=0, MAX_BURST=4 -> req0 gets 4 beats (cycles 0-3), then req2 gets 4 beats, then req0 again.
REQ-035 Owner req1 drops valid after 2 beats -> one bubble cycle, then rr_ptr=2, next grant to req2/3/0 in that order.
REQ-036 full=1 for 3 cycles mid-burst at beat_cnt=2 -> ready=0 and wr_en=0 for those cycles; the burst resumes at beat 3 with the same owner.
REQ-037 All 4 valid, MAX_BURST=1 -> grants 0,1,2,3,0 on successive cycles; wr_en high every cycle.
REQ-038 rst_i asserted asynchronously mid-burst (owner 3) -> outputs 0 immediately; after release with all valid, the first grant is req0.
REQ-039 With FIFO_ARB_TAG_EN, req2 writes 8'hA5 -> fifo_wdata_o = {2'd2, 8'hA5}; without the macro -> 8'hA5.
